// File: rtl/wave_gen_multi.sv
// Multi-channel square-wave generator with per-channel start/stop FSM and shadowed half-period.
// Optional WAVE_GEN_TRISTATE_EN adds wave_oe and floats wave_out of idle channels.

module wave_gen_ch #(
  parameter int CNT_W    = 16,
  parameter int RESET_HP = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic             wave,
  output logic             rise,
  output logic             act,
  output logic             pend,
  output logic [CNT_W-1:0] hp
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} st_t;

  st_t              st;
  logic [CNT_W-1:0] cnt, hp_sh, hp_eff;
  logic             tog, fall;

  // hp==0 behaves as hp==1
  assign hp_eff = (hp == '0) ? CNT_W'(1) : hp;
  assign tog    = (cnt == hp_eff - CNT_W'(1));
  assign fall   = tog && wave;
  assign act    = (st != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      wave  <= 1'b0;
      rise  <= 1'b0;
      pend  <= 1'b0;
      hp    <= CNT_W'(RESET_HP);
      hp_sh <= CNT_W'(RESET_HP);
    end else begin
      rise <= 1'b0;
      case (st)
        IDLE: begin
          cnt  <= '0;
          wave <= 1'b0;
          if (we) begin
            hp_sh <= wdata;
            hp    <= wdata;
            pend  <= 1'b0;
          end
          if (en) begin
            st   <= RUN;
            pend <= 1'b0;
            if (!we) hp <= hp_sh;
          end
        end
        default: begin
          if (st == RUN && !en && !wave) begin
            // low phase: stop at once, never emit a partial high pulse
            st  <= IDLE;
            cnt <= '0;
          end else begin
            cnt  <= tog ? '0 : cnt + CNT_W'(1);
            rise <= tog && !wave;
            if (tog) wave <= ~wave;
            if (fall) begin
              hp   <= hp_sh;
              pend <= 1'b0;
            end
            if (fall && !en) st <= IDLE;
            else             st <= en ? RUN : STOP;
          end
          // a write landing on the applying edge stays pending for the next period
          if (we) begin
            hp_sh <= wdata;
            pend  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module wave_gen_multi #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int CH_IDX_W = 2,
  parameter int RESET_HP = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_half_period,
  output logic [CNT_W-1:0]    cfg_rdata,
  output logic [NUM_CH-1:0]   wave_out,
  output logic [NUM_CH-1:0]   rise_stb,
  output logic [NUM_CH-1:0]   active,
`ifdef WAVE_GEN_TRISTATE_EN
  output logic [NUM_CH-1:0]   wave_oe,
`endif
  output logic [NUM_CH-1:0]   pending
);
  logic [NUM_CH-1:0]            wave_r;
  logic [NUM_CH-1:0][CNT_W-1:0] hp_act;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wave_gen_ch #(.CNT_W(CNT_W), .RESET_HP(RESET_HP)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ch_en[i]),
      .we    (cfg_we && (cfg_ch == CH_IDX_W'(i))),
      .wdata (cfg_half_period),
      .wave  (wave_r[i]),
      .rise  (rise_stb[i]),
      .act   (active[i]),
      .pend  (pending[i]),
      .hp    (hp_act[i])
    );
`ifdef WAVE_GEN_TRISTATE_EN
    assign wave_out[i] = active[i] ? wave_r[i] : 1'bz;
`else
    assign wave_out[i] = wave_r[i];
`endif
  end

`ifdef WAVE_GEN_TRISTATE_EN
  assign wave_oe = active;
`endif

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_IDX_W'(i)) cfg_rdata = hp_act[i];
  end
endmodule

// File: tb/tb_wave_gen_multi.sv
// Random-stimulus bench for wave_gen_multi against a phase-position reference model.
module tb_wave_gen_multi;
  localparam int NCH = 3;
  localparam int HP0 = 5;
`ifdef WAVE_GEN_TRISTATE_EN
  localparam logic IDLE_LVL = 1'bz;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  ch_en;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [15:0]     cfg_half_period;
  logic [15:0]     cfg_rdata;
  logic [NCH-1:0]  wave_out, rise_stb, active, pending;
`ifdef WAVE_GEN_TRISTATE_EN
  logic [NCH-1:0]  wave_oe;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // reference model: ph = cycles into the current period, high while ph >= hp
  bit m_run[NCH], m_pend[NCH], m_rise[NCH];
  int m_ph[NCH], m_act[NCH], m_sh[NCH];

  always #5 clk = ~clk;

  wave_gen_multi #(.NUM_CH(NCH), .CNT_W(16), .CH_IDX_W(2), .RESET_HP(HP0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ch_en           (ch_en),
    .cfg_we          (cfg_we),
    .cfg_ch          (cfg_ch),
    .cfg_half_period (cfg_half_period),
    .cfg_rdata       (cfg_rdata),
    .wave_out        (wave_out),
    .rise_stb        (rise_stb),
    .active          (active),
`ifdef WAVE_GEN_TRISTATE_EN
    .wave_oe         (wave_oe),
`endif
    .pending         (pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  function automatic int hval(input int c);
    return (m_act[c] == 0) ? 1 : m_act[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_rise[c] = 0;
      m_ph[c] = 0; m_act[c] = HP0; m_sh[c] = HP0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit en, wr, hi;
      int v, h;
      en = ch_en[c];
      wr = cfg_we && (int'(cfg_ch) == c);
      v  = int'(cfg_half_period);
      m_rise[c] = 0;
      if (!m_run[c]) begin
        if (wr) begin m_sh[c] = v; m_act[c] = v; m_pend[c] = 0; end
        if (en) begin m_run[c] = 1; m_ph[c] = 0; m_act[c] = m_sh[c]; m_pend[c] = 0; end
      end else begin
        h  = hval(c);
        hi = (m_ph[c] >= h);
        if (!en && !hi) begin
          m_run[c] = 0; m_ph[c] = 0;
        end else if (m_ph[c] + 1 == 2 * h) begin
          m_act[c] = m_sh[c]; m_pend[c] = 0; m_ph[c] = 0;
          if (!en) m_run[c] = 0;
        end else begin
          m_ph[c]++;
          m_rise[c] = (m_ph[c] == h);
        end
        if (wr) begin m_sh[c] = v; m_pend[c] = 1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] ew, er, ea, ep;
    logic [15:0]    ed;
    for (int c = 0; c < NCH; c++) begin
      ea[c] = m_run[c];
      ep[c] = m_pend[c];
      er[c] = m_rise[c];
      ew[c] = m_run[c] ? logic'(m_ph[c] >= hval(c)) : IDLE_LVL;
    end
    ed = (int'(cfg_ch) < NCH) ? 16'(m_act[int'(cfg_ch)]) : 16'd0;
    chk({tag, "/wave"},    32'(wave_out), 32'(ew));
    chk({tag, "/rise"},    32'(rise_stb), 32'(er));
    chk({tag, "/active"},  32'(active),   32'(ea));
    chk({tag, "/pending"}, 32'(pending),  32'(ep));
    chk({tag, "/rdata"},   32'(cfg_rdata), 32'(ed));
`ifdef WAVE_GEN_TRISTATE_EN
    chk({tag, "/oe"},      32'(wave_oe),  32'(ea));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all(tag);
  endtask

  task automatic write(input int ch, input int hp, input string tag);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_half_period = 16'(hp);
    cycle(tag);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_half_period = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1 check_all("reset");
    end
    rst_n = 1'b1;

    // defaults: all channels at hp=5
    ch_en = '1;
    cfg_ch = 2'd1;
    repeat (40) cycle("t1");

    // hp sweep from idle, then glitch-free reprogram while running
    ch_en = '0;
    repeat (12) cycle("t2idle");
    write(0, 1, "t2");
    write(1, 7, "t2");
    write(2, 13, "t2");
    ch_en = '1;
    repeat (60) cycle("t2");
    write(0, 5, "t3");
    repeat (20) cycle("t3");
    write(0, 3, "t3");
    write(0, 2, "t3");
    repeat (30) cycle("t3");

    // hp=0, out-of-range channel
    write(1, 0, "t5");
    repeat (30) cycle("t5");
    write(3, 9, "t5bad");
    cfg_ch = 2'd3;
    repeat (4) cycle("t5bad");

    // random stop/start/reprogram traffic
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_half_period = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40))
                                                    : 16'($urandom_range(0, 8));
      cycle("rnd");
    end
    cfg_we = 1'b0;

    // async reset mid-period with all channels running
    ch_en = '1;
    cfg_ch = 2'd2;
    repeat (23) cycle("prerst");
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ch_en = 3'b101;
    repeat (30) cycle("postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
